id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and reset_n, with all state updated on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset_n  in  1  synchronous active-low reset.
REQ-004 RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  32 each  decode-stage register operands, extended immediate, PC, PC+4.
REQ-005 Rs1D, Rs2D, RdD  in  5 each  decode-stage register indices.
REQ-006 ALUControlD  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-007 ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD  in  1 each; ResultSrcD  in  2  decode control.
REQ-008 StallE, FlushE  in  1 each  hazard-unit hold / bubble-insert requests.
REQ-009 ForwardAE, ForwardBE  in  2 each  operand source select.
REQ-010 ALUResultM, ResultW  in  32 each  memory-stage ALU result, writeback result.
REQ-011 ZeroE  in  1  zero flag returned by the ALU for the current E-stage op.
REQ-012 SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E  out  32 each  ALU operands, store data, branch/jump target, link value.
REQ-013 ALUControlE  out  3; Rs1E, Rs2E, RdE  out  5 each; RegWriteE, MemWriteE, PCSrcE  out  1 each; ResultSrcE  out  2.

Function
REQ-014 The block SHALL hold one ID/EX register for every D-suffixed input; each E-suffixed output is its registered counterpart or derived from it combinationally.
REQ-015 Update priority per edge SHALL be: reset_n=0, then FlushE=1, then StallE=1, then load.
REQ-016 Load: all registers take D inputs; latency D to E is exactly one cycle.
REQ-017 StallE=1 (FlushE=0) SHALL hold every register unchanged.
REQ-018 FlushE=1 SHALL load a bubble: RegWrite, MemWrite, Branch, Jump, ALUSrc = 0; ResultSrc = 00; ALUControl = 000; Rs1, Rs2, Rd = 0; data registers (RD1, RD2, ImmExt, PC, PCPlus4) = 0.
REQ-019 FlushE and StallE both 1 SHALL produce the bubble (flush wins).
REQ-020 Forwarded A SHALL be: ForwardAE 00 registered RD1; 01 ResultW; 10 ALUResultM; 11 registered RD1. Forwarded B identical with ForwardBE and RD2.
REQ-021 SrcAE = forwarded A; WriteDataE = forwarded B; SrcBE = registered ImmExt when registered ALUSrc=1, else forwarded B.
REQ-022 PCTargetE SHALL be registered PC + registered ImmExt, modulo 2^32 (carry discarded).
REQ-023 PCSrcE SHALL be (BranchE AND ZeroE) OR JumpE, combinational from registered Branch/Jump and current ZeroE.
REQ-024 Forward muxes and PCSrcE SHALL be purely combinational; forward/result inputs are not registered in this block.
REQ-025 ALUControlD codes outside REQ-006 SHALL be passed through unchanged.

Reset
REQ-026 With reset_n=0 at a rising edge, every register SHALL take the bubble value of REQ-018, regardless of StallE/FlushE.
REQ-027 Post-reset outputs with ForwardAE=ForwardBE=00: SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E = 0; ALUControlE = 000; RegWriteE, MemWriteE, PCSrcE = 0; ResultSrcE = 00; Rs1E, Rs2E, RdE = 0.
REQ-028 Reset asserted mid-stall SHALL clear state on that edge; first edge after release loads D inputs if StallE=0.

Verification
REQ-029 Load: RD1D=5, RD2D=7, ALUSrcD=0, ALUControlD=001, RegWriteD=1, RdD=3, Forward*=00, one edge -> SrcAE=5, SrcBE=7, WriteDataE=7, ALUControlE=001, RegWriteE=1, RdE=3.
REQ-030 Immediate/target: PCD=0x100, ImmExtD=0xFFFFFFF0, ALUSrcD=1, RD2D=9, one edge -> SrcBE=0xFFFFFFF0, WriteDataE=9, PCTargetE=0xF0.
REQ-031 Forwarding: registered RD1=1, RD2=2, ALUResultM=0xAA, ResultW=0xBB; ForwardAE=10, ForwardBE=01 -> SrcAE=0xAA, SrcBE=0xBB; ForwardAE=11 -> SrcAE=1.
REQ-032 Branch: BranchD=1, JumpD=0 loaded; ZeroE=1 -> PCSrcE=1; ZeroE=0 -> PCSrcE=0; JumpD=1 loaded -> PCSrcE=1 for either ZeroE.
REQ-033 Stall/flush: load RdD=4, RegWriteD=1; next edge StallE=1 with RdD=9 -> RdE=4; next edge StallE=1, FlushE=1 -> RdE=0, RegWriteE=0, MemWriteE=0.
REQ-034 Reset: registers loaded nonzero, reset_n=0 with StallE=1 for one edge -> all outputs per REQ-027; reset_n=1, StallE=0, RdD=6 next edge -> RdE=6.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with E-stage operand forwarding.
//
// Purpose:
//   Captures the decode-stage operands, immediate, PC values, register indices
//   and control bits into one ID/EX register bank. The E-stage outputs are
//   built from that bank:
//     - forwarding muxes select ALU operands and store data;
//     - an adder forms the branch/jump target;
//     - PCSrcE combines the registered branch/jump bits with the ALU zero flag.
//
// Ports:
//   clk, reset_n                  rising-edge clock, synchronous active-low reset
//   RD1D, RD2D, ImmExtD           decode operands and extended immediate (32)
//   PCD, PCPlus4D                 decode PC and PC+4 (32)
//   Rs1D, Rs2D, RdD               decode register indices (5)
//   ALUControlD (3), ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD,
//   ResultSrcD (2)                decode control
//   StallE, FlushE                hazard-unit hold / bubble requests
//   ForwardAE, ForwardBE          operand source selects (2)
//   ALUResultM, ResultW           forwarded results from M and W (32)
//   ZeroE                         ALU zero flag for the current E-stage op
//   SrcAE, SrcBE, WriteDataE      ALU operands and store data (32)
//   PCTargetE, PCPlus4E           branch/jump target and link value (32)
//   ALUControlE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, ResultSrcE
//                                 registered control/indices
//   PCSrcE                        take-branch/jump indication
//
// Hazard control: on each rising edge reset_n=0 wins, then FlushE (load a
// bubble of all zeros), then StallE (hold), otherwise the bank loads.
// Flush beats stall so that a squashed instruction never lingers in E.

module id_ex_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] ImmExtD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic [2:0]  ALUControlD,
    input  logic        ALUSrcD,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic [1:0]  ResultSrcD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    input  logic        ZeroE,
    output logic [31:0] SrcAE,
    output logic [31:0] SrcBE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCTargetE,
    output logic [31:0] PCPlus4E,
    output logic [2:0]  ALUControlE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        PCSrcE,
    output logic [1:0]  ResultSrcE
);

    logic [31:0] rd1_e;
    logic [31:0] rd2_e;
    logic [31:0] imm_ext_e;
    logic [31:0] pc_e;
    logic [31:0] pc_plus4_e;
    logic [4:0]  rs1_e;
    logic [4:0]  rs2_e;
    logic [4:0]  rd_e;
    logic [2:0]  alu_control_e;
    logic        alu_src_e;
    logic        reg_write_e;
    logic        mem_write_e;
    logic        branch_e;
    logic        jump_e;
    logic [1:0]  result_src_e;

    always_ff @(posedge clk) begin
        if (!reset_n || FlushE) begin
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_ext_e     <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            alu_control_e <= '0;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            branch_e      <= 1'b0;
            jump_e        <= 1'b0;
            result_src_e  <= '0;
        end else if (!StallE) begin
            rd1_e         <= RD1D;
            rd2_e         <= RD2D;
            imm_ext_e     <= ImmExtD;
            pc_e          <= PCD;
            pc_plus4_e    <= PCPlus4D;
            rs1_e         <= Rs1D;
            rs2_e         <= Rs2D;
            rd_e          <= RdD;
            alu_control_e <= ALUControlD;
            alu_src_e     <= ALUSrcD;
            reg_write_e   <= RegWriteD;
            mem_write_e   <= MemWriteD;
            branch_e      <= BranchD;
            jump_e        <= JumpD;
            result_src_e  <= ResultSrcD;
        end
    end

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    // Select 11 is unused by the hazard unit; it falls back to the register.
    always_comb begin
        fwd_a = rd1_e;
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALUResultM;
            default: fwd_a = rd1_e;
        endcase
    end

    always_comb begin
        fwd_b = rd2_e;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = rd2_e;
        endcase
    end

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = alu_src_e ? imm_ext_e : fwd_b;
    assign PCTargetE   = pc_e + imm_ext_e;  // 32-bit wrap, carry dropped
    assign PCPlus4E    = pc_plus4_e;
    assign PCSrcE      = (branch_e & ZeroE) | jump_e;
    assign ALUControlE = alu_control_e;
    assign Rs1E        = rs1_e;
    assign Rs2E        = rs2_e;
    assign RdE         = rd_e;
    assign RegWriteE   = reg_write_e;
    assign MemWriteE   = mem_write_e;
    assign ResultSrcE  = result_src_e;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed-vector bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk;
    logic        reset_n;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [2:0]  ALUControlD;
    logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
    logic [1:0]  ResultSrcD;
    logic        StallE, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW;
    logic        ZeroE;
    logic [31:0] SrcAE, SrcBE, WriteDataE, PCTargetE, PCPlus4E;
    logic [2:0]  ALUControlE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, PCSrcE;
    logic [1:0]  ResultSrcE;

    int n_cmp;
    int n_fail;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD), .RegWriteD(RegWriteD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD), .ResultSrcD(ResultSrcD),
        .StallE(StallE), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW), .ZeroE(ZeroE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
        .PCPlus4E(PCPlus4E), .ALUControlE(ALUControlE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .ResultSrcE(ResultSrcE)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nonzero();
        RD1D = 32'h1111_1111; RD2D = 32'h2222_2222; ImmExtD = 32'h0000_0040;
        PCD = 32'h0000_2000; PCPlus4D = 32'h0000_2004;
        Rs1D = 5'd7; Rs2D = 5'd8; RdD = 5'd9; ALUControlD = 3'b011;
        ALUSrcD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1;
        BranchD = 1'b0; JumpD = 1'b1; ResultSrcD = 2'b10;
    endtask

    task automatic check_bubble(input string pfx);
        check({pfx, ".SrcAE"},       SrcAE, 32'h0);
        check({pfx, ".SrcBE"},       SrcBE, 32'h0);
        check({pfx, ".WriteDataE"},  WriteDataE, 32'h0);
        check({pfx, ".PCTargetE"},   PCTargetE, 32'h0);
        check({pfx, ".PCPlus4E"},    PCPlus4E, 32'h0);
        check({pfx, ".ALUControlE"}, {29'h0, ALUControlE}, 32'h0);
        check({pfx, ".RegWriteE"},   {31'h0, RegWriteE}, 32'h0);
        check({pfx, ".MemWriteE"},   {31'h0, MemWriteE}, 32'h0);
        check({pfx, ".PCSrcE"},      {31'h0, PCSrcE}, 32'h0);
        check({pfx, ".ResultSrcE"},  {30'h0, ResultSrcE}, 32'h0);
        check({pfx, ".Rs1E"},        {27'h0, Rs1E}, 32'h0);
        check({pfx, ".Rs2E"},        {27'h0, Rs2E}, 32'h0);
        check({pfx, ".RdE"},         {27'h0, RdE}, 32'h0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        ALUResultM = 32'h0; ResultW = 32'h0; ZeroE = 1'b1;
        drive_nonzero();

        // reset with nonzero D inputs present
        tick(); tick();
        check_bubble("reset");

        // load
        reset_n = 1'b1;
        RD1D = 32'd5; RD2D = 32'd7; ALUSrcD = 1'b0; ALUControlD = 3'b001;
        RegWriteD = 1'b1; RdD = 5'd3; JumpD = 1'b0; BranchD = 1'b0;
        tick();
        check("load.SrcAE", SrcAE, 32'd5);
        check("load.SrcBE", SrcBE, 32'd7);
        check("load.WriteDataE", WriteDataE, 32'd7);
        check("load.ALUControlE", {29'h0, ALUControlE}, 32'd1);
        check("load.RegWriteE", {31'h0, RegWriteE}, 32'd1);
        check("load.RdE", {27'h0, RdE}, 32'd3);
        check("load.Rs1E", {27'h0, Rs1E}, 32'd7);
        check("load.ResultSrcE", {30'h0, ResultSrcE}, 32'd2);

        // immediate / target with wraparound
        PCD = 32'h100; PCPlus4D = 32'h104; ImmExtD = 32'hFFFF_FFF0; ALUSrcD = 1'b1; RD2D = 32'd9;
        tick();
        check("imm.SrcBE", SrcBE, 32'hFFFF_FFF0);
        check("imm.WriteDataE", WriteDataE, 32'd9);
        check("imm.PCTargetE", PCTargetE, 32'h0000_00F0);
        check("imm.PCPlus4E", PCPlus4E, 32'h104);

        // forwarding
        RD1D = 32'd1; RD2D = 32'd2; ALUSrcD = 1'b0;
        tick();
        ALUResultM = 32'hAA; ResultW = 32'hBB; ForwardAE = 2'b10; ForwardBE = 2'b01;
        #1;
        check("fwd.A10", SrcAE, 32'hAA);
        check("fwd.B01", SrcBE, 32'hBB);
        check("fwd.WD01", WriteDataE, 32'hBB);
        ForwardAE = 2'b11; ForwardBE = 2'b10; #1;
        check("fwd.A11", SrcAE, 32'd1);
        check("fwd.B10", SrcBE, 32'hAA);
        ForwardAE = 2'b01; ForwardBE = 2'b11; #1;
        check("fwd.A01", SrcAE, 32'hBB);
        check("fwd.B11", SrcBE, 32'd2);
        ForwardAE = 2'b00; ForwardBE = 2'b00;

        // branch / jump
        BranchD = 1'b1; JumpD = 1'b0;
        tick();
        ZeroE = 1'b1; #1;
        check("br.z1", {31'h0, PCSrcE}, 32'd1);
        ZeroE = 1'b0; #1;
        check("br.z0", {31'h0, PCSrcE}, 32'd0);
        BranchD = 1'b0; JumpD = 1'b1;
        tick();
        check("jmp.z0", {31'h0, PCSrcE}, 32'd1);
        ZeroE = 1'b1; #1;
        check("jmp.z1", {31'h0, PCSrcE}, 32'd1);
        JumpD = 1'b0;

        // ALU control pass-through of unlisted codes
        ALUControlD = 3'b111;
        tick();
        check("aluctl.111", {29'h0, ALUControlE}, 32'd7);
        ALUControlD = 3'b101;
        tick();
        check("aluctl.101", {29'h0, ALUControlE}, 32'd5);

        // stall then flush+stall
        RdD = 5'd4; RegWriteD = 1'b1; MemWriteD = 1'b1;
        tick();
        StallE = 1'b1; RdD = 5'd9; RegWriteD = 1'b0;
        tick();
        check("stall.RdE", {27'h0, RdE}, 32'd4);
        check("stall.RegWriteE", {31'h0, RegWriteE}, 32'd1);
        FlushE = 1'b1;
        tick();
        check("flush.RdE", {27'h0, RdE}, 32'd0);
        check("flush.RegWriteE", {31'h0, RegWriteE}, 32'd0);
        check("flush.MemWriteE", {31'h0, MemWriteE}, 32'd0);
        check("flush.SrcAE", SrcAE, 32'h0);
        StallE = 1'b0; FlushE = 1'b0;

        // flush alone after a nonzero load
        drive_nonzero();
        tick();
        check("pre_flush.RdE", {27'h0, RdE}, 32'd9);
        check("pre_flush.PCTargetE", PCTargetE, 32'h0000_2040);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0; ZeroE = 1'b1;
        check_bubble("flush_only");

        // reset while stalled, then release
        drive_nonzero();
        tick();
        reset_n = 1'b0; StallE = 1'b1;
        tick();
        check_bubble("reset_stall");
        reset_n = 1'b1; StallE = 1'b0; RdD = 5'd6;
        tick();
        check("post_reset.RdE", {27'h0, RdE}, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
